// File: rtl/snn_inference_engine.sv
// Time-stepped leaky integrate-and-fire classifier: buffers a pixel frame, rate-encodes it with an
// LFSR each timestep, accumulates one crossbar row per cycle, fires, and reports the argmax class.
module snn_inference_engine #(
    parameter int          N_INPUTS    = 784,
    parameter int          N_OUTPUTS   = 10,
    parameter int          DATA_WIDTH  = 8,
    parameter int          N_TIMESTEPS = 32,
    parameter int          MEM_WIDTH   = 24,
    parameter int          CNT_WIDTH   = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic signed [MEM_WIDTH-1:0]       cfg_threshold,
    input  logic [3:0]                        cfg_leak_shift,
    input  logic                              weight_wen,
    input  logic [$clog2(N_INPUTS)-1:0]       weight_addr_row,
    input  logic [$clog2(N_OUTPUTS)-1:0]      weight_addr_col,
    input  logic signed [DATA_WIDTH-1:0]      weight_data,
    input  logic [DATA_WIDTH-1:0]             pixel_data,
    input  logic                              pixel_valid,
    output logic                              pixel_ready,
    output logic                              busy,
    output logic [N_OUTPUTS-1:0]              out_spikes,
    output logic                              out_spikes_valid,
    output logic [N_OUTPUTS*CNT_WIDTH-1:0]    spike_counts,
    output logic [$clog2(N_OUTPUTS)-1:0]      winner,
    output logic                              done
);
    localparam int ROW_W = $clog2(N_INPUTS);
    localparam int COL_W = $clog2(N_OUTPUTS);
    localparam int TS_W  = (N_TIMESTEPS > 1) ? $clog2(N_TIMESTEPS) : 1;
    localparam logic signed [MEM_WIDTH-1:0] MEM_MAX = {1'b0, {(MEM_WIDTH-1){1'b1}}};
    localparam logic signed [MEM_WIDTH-1:0] MEM_MIN = {1'b1, {(MEM_WIDTH-1){1'b0}}};
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_INPUTS - 1);
    localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(N_TIMESTEPS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INTEG, S_FIRE, S_ARGMAX} state_t;
    state_t r_state, w_nextState;

    logic signed [DATA_WIDTH-1:0] r_weights [N_INPUTS][N_OUTPUTS];
    logic [DATA_WIDTH-1:0]        r_pixels  [N_INPUTS];
    logic signed [MEM_WIDTH-1:0]  r_mem     [N_OUTPUTS];
    logic [CNT_WIDTH-1:0]         r_cnt     [N_OUTPUTS];
    logic signed [MEM_WIDTH-1:0]  r_threshold;
    logic [3:0]                   r_shift;
    logic [15:0]                  r_lfsr;
    logic [ROW_W-1:0]             r_idx;
    logic [TS_W-1:0]              r_ts;
    logic [N_OUTPUTS-1:0]         r_outSpikes;
    logic                         r_outValid;
    logic [COL_W-1:0]             r_winner;
    logic                         r_done;

    logic signed [MEM_WIDTH-1:0]  w_integMem [N_OUTPUTS];
    logic signed [MEM_WIDTH-1:0]  w_fireMem  [N_OUTPUTS];
    logic [N_OUTPUTS-1:0]         w_fire;
    logic                         w_spike;
    logic                         w_addrOk;
    logic [15:0]                  w_lfsrNext;
    logic [COL_W-1:0]             w_best;
    logic [CNT_WIDTH-1:0]         w_bestCnt;

    assign w_addrOk   = (32'(weight_addr_row) < 32'(N_INPUTS)) && (32'(weight_addr_col) < 32'(N_OUTPUTS));
    assign w_spike    = (r_lfsr[DATA_WIDTH-1:0] < r_pixels[r_idx]) ||
                        (r_pixels[r_idx] == {DATA_WIDTH{1'b1}});
    assign w_lfsrNext = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

    // Per-neuron saturating accumulate for the current row, and the fire/leak decision.
    for (genvar g = 0; g < N_OUTPUTS; g++) begin : g_neuron
        logic signed [MEM_WIDTH:0]   w_sum;
        logic signed [MEM_WIDTH-1:0] w_leak;
        assign w_sum = {r_mem[g][MEM_WIDTH-1], r_mem[g]} +
                       {{(MEM_WIDTH+1-DATA_WIDTH){r_weights[r_idx][g][DATA_WIDTH-1]}}, r_weights[r_idx][g]};
        assign w_integMem[g] = (w_sum[MEM_WIDTH] != w_sum[MEM_WIDTH-1]) ?
                               (w_sum[MEM_WIDTH] ? MEM_MIN : MEM_MAX) : w_sum[MEM_WIDTH-1:0];
        assign w_fire[g]     = r_mem[g] >= r_threshold;
        assign w_leak        = r_mem[g] - (r_mem[g] >>> r_shift);
        assign w_fireMem[g]  = w_fire[g] ? '0 : ((r_shift != 4'd0) ? w_leak : r_mem[g]);
        assign spike_counts[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
    end

    // Strict greater-than keeps the lowest index on ties and yields 0 when all counts are zero.
    always_comb begin
        w_best    = '0;
        w_bestCnt = r_cnt[0];
        for (int j = 1; j < N_OUTPUTS; j++) begin
            if (r_cnt[j] > w_bestCnt) begin
                w_bestCnt = r_cnt[j];
                w_best    = COL_W'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        pixel_ready = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_nextState = S_LOAD;
            end
            S_LOAD: begin
                pixel_ready = 1'b1;
                if (pixel_valid && r_idx == LAST_ROW) w_nextState = S_INTEG;
            end
            S_INTEG:  if (r_idx == LAST_ROW) w_nextState = S_FIRE;
            S_FIRE:   w_nextState = (r_ts == LAST_TS) ? S_ARGMAX : S_INTEG;
            S_ARGMAX: w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // The row/pixel index wraps to zero on its last value so every timestep starts at row 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                r_pixels[i] <= '0;
                for (int j = 0; j < N_OUTPUTS; j++) r_weights[i][j] <= '0;
            end
            for (int j = 0; j < N_OUTPUTS; j++) begin
                r_mem[j] <= '0;
                r_cnt[j] <= '0;
            end
            r_threshold <= '0;
            r_shift     <= '0;
            r_lfsr      <= LFSR_SEED;
            r_idx       <= '0;
            r_ts        <= '0;
            r_outSpikes <= '0;
            r_outValid  <= 1'b0;
            r_winner    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (weight_wen && w_addrOk) r_weights[weight_addr_row][weight_addr_col] <= weight_data;
                    if (start) begin
                        for (int j = 0; j < N_OUTPUTS; j++) begin
                            r_mem[j] <= '0;
                            r_cnt[j] <= '0;
                        end
                        r_winner    <= '0;
                        r_outSpikes <= '0;
                        r_idx       <= '0;
                        r_ts        <= '0;
                        r_lfsr      <= LFSR_SEED;
                        r_threshold <= cfg_threshold;
                        r_shift     <= cfg_leak_shift;
                    end
                end
                S_LOAD: begin
                    if (pixel_valid) begin
                        r_pixels[r_idx] <= pixel_data;
                        r_idx <= (r_idx == LAST_ROW) ? '0 : r_idx + 1'b1;
                    end
                end
                S_INTEG: begin
                    if (w_spike) begin
                        for (int j = 0; j < N_OUTPUTS; j++) r_mem[j] <= w_integMem[j];
                    end
                    r_lfsr <= w_lfsrNext;
                    r_idx  <= (r_idx == LAST_ROW) ? '0 : r_idx + 1'b1;
                end
                S_FIRE: begin
                    for (int j = 0; j < N_OUTPUTS; j++) begin
                        r_mem[j] <= w_fireMem[j];
                        if (w_fire[j] && r_cnt[j] != {CNT_WIDTH{1'b1}}) r_cnt[j] <= r_cnt[j] + 1'b1;
                    end
                    r_outSpikes <= w_fire;
                    r_outValid  <= 1'b1;
                    if (r_ts != LAST_TS) r_ts <= r_ts + 1'b1;
                end
                S_ARGMAX: begin
                    r_winner <= w_best;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_spikes       = r_outSpikes;
    assign out_spikes_valid = r_outValid;
    assign winner           = r_winner;
    assign done             = r_done;

endmodule

// File: tb/tb_snn_inference_engine.sv
// Scoreboard bench for snn_inference_engine: a behavioural model predicts per-timestep spikes,
// final counts, winner and done latency; a monitor compares them whenever the DUT presents results.
module tb_snn_inference_engine;
    localparam int NI = 16;
    localparam int NO = 4;
    localparam int NT = 4;
    localparam int DW = 8;
    localparam int MW = 12;
    localparam int CW = 16;
    localparam int MEM_MAX = (1 << (MW - 1)) - 1;
    localparam int MEM_MIN = -(1 << (MW - 1));

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [MW-1:0]     cfg_threshold;
    logic [3:0]        cfg_leak_shift;
    logic              weight_wen;
    logic [3:0]        weight_addr_row;
    logic [1:0]        weight_addr_col;
    logic [DW-1:0]     weight_data;
    logic [DW-1:0]     pixel_data;
    logic              pixel_valid;
    logic              pixel_ready;
    logic              busy;
    logic [NO-1:0]     out_spikes;
    logic              out_spikes_valid;
    logic [NO*CW-1:0]  spike_counts;
    logic [1:0]        winner;
    logic              done;

    snn_inference_engine #(
        .N_INPUTS(NI), .N_OUTPUTS(NO), .DATA_WIDTH(DW), .N_TIMESTEPS(NT),
        .MEM_WIDTH(MW), .CNT_WIDTH(CW), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_threshold(cfg_threshold), .cfg_leak_shift(cfg_leak_shift),
        .weight_wen(weight_wen), .weight_addr_row(weight_addr_row),
        .weight_addr_col(weight_addr_col), .weight_data(weight_data),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .busy(busy), .out_spikes(out_spikes), .out_spikes_valid(out_spikes_valid),
        .spike_counts(spike_counts), .winner(winner), .done(done)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NO*CW-1:0] counts;
        logic [1:0]       win;
        longint           doneCyc;
    } res_t;

    res_t          resQ[$];
    logic [NO-1:0] spkQ[$];
    int nChecks = 0;
    int nPass = 0;
    int pulseCnt = 0;

    int            tbW [NI][NO];
    int            tbPix [NI];
    logic [NO-1:0] mSpk [NT];
    int            mCnt [NO];
    int            mWin;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int satMem(input int v);
        if (v > MEM_MAX) return MEM_MAX;
        if (v < MEM_MIN) return MEM_MIN;
        return v;
    endfunction

    // Reference: rate-encode, integrate, fire and leak with plain integer arithmetic.
    function automatic void runModel(input int thr, input int sh);
        int v [NO];
        logic [15:0] lfsr;
        int best;
        lfsr = 16'hACE1;
        for (int j = 0; j < NO; j++) begin
            v[j] = 0;
            mCnt[j] = 0;
        end
        for (int t = 0; t < NT; t++) begin
            for (int i = 0; i < NI; i++) begin
                if ((int'(lfsr[7:0]) < tbPix[i]) || (tbPix[i] == 255)) begin
                    for (int j = 0; j < NO; j++) v[j] = satMem(v[j] + tbW[i][j]);
                end
                lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            end
            mSpk[t] = '0;
            for (int j = 0; j < NO; j++) begin
                if (v[j] >= thr) begin
                    mSpk[t][j] = 1'b1;
                    v[j] = 0;
                    mCnt[j]++;
                end else if (sh != 0) begin
                    v[j] = v[j] - (v[j] >>> sh);
                end
            end
        end
        best = 0;
        for (int j = 1; j < NO; j++) if (mCnt[j] > mCnt[best]) best = j;
        mWin = best;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a spike vector or completes.
    always @(negedge clk) begin : monitor
        logic [NO-1:0] e;
        res_t r;
        if (!rst) begin
            if (out_spikes_valid) begin
                pulseCnt++;
                if (spkQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL spike_pulse: got unexpected pulse 0x%0h, expected none", out_spikes);
                end else begin
                    e = spkQ.pop_front();
                    checkOutput("out_spikes", out_spikes, e);
                end
            end
            if (done) begin
                if (resQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL done_pulse: got unexpected done at cycle %0d, expected none", cyc);
                end else begin
                    r = resQ.pop_front();
                    checkOutput("spike_counts", spike_counts, r.counts);
                    checkOutput("winner", winner, r.win);
                    checkOutput("done_latency", cyc, r.doneCyc);
                    checkOutput("busy_in_done", busy, 0);
                end
            end
        end
    end

    task automatic writeWeight(input int r, input int c, input int val);
        @(negedge clk);
        weight_wen      = 1'b1;
        weight_addr_row = 4'(r);
        weight_addr_col = 2'(c);
        weight_data     = 8'(val);
        tbW[r][c]       = val;
        @(negedge clk);
        weight_wen = 1'b0;
    endtask

    task automatic setAllWeights();
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++) writeWeight(i, j, tbW[i][j]);
    endtask

    // Runs one inference; abortTs >= 0 resets the DUT during that timestep's integration.
    task automatic applyStimulus(input int thr, input int sh, input int abortTs,
                                 input bit wenAtStart, input bit busyPoke);
        longint lastCyc;
        int accepted;
        int guard;
        int nTs;
        res_t r;
        lastCyc = 0;
        @(negedge clk);
        if (wenAtStart) begin
            int wr, wc, wd;
            wr = int'($urandom_range(0, NI - 1));
            wc = int'($urandom_range(0, NO - 1));
            wd = int'($urandom_range(0, 255)) - 128;
            weight_wen = 1'b1; weight_addr_row = 4'(wr); weight_addr_col = 2'(wc); weight_data = 8'(wd);
            tbW[wr][wc] = wd;
        end
        start = 1'b1;
        cfg_threshold = MW'(thr);
        cfg_leak_shift = 4'(sh);
        runModel(thr, sh);
        nTs = (abortTs < 0) ? NT : abortTs;
        for (int t = 0; t < nTs; t++) spkQ.push_back(mSpk[t]);
        @(negedge clk);
        start = 1'b0;
        weight_wen = 1'b0;
        cfg_threshold = MW'($urandom);
        cfg_leak_shift = 4'($urandom);
        checkOutput("pixel_ready_after_start", pixel_ready, 1);
        accepted = 0;
        guard = 0;
        while (accepted < NI && guard < 2000) begin
            pixel_valid = ($urandom_range(0, 2) != 0);
            pixel_data  = pixel_valid ? 8'(tbPix[accepted]) : 8'($urandom);
            if (pixel_valid && pixel_ready) begin
                accepted++;
                lastCyc = cyc + 1;
            end
            @(negedge clk);
            guard++;
        end
        pixel_valid = 1'b0;
        checkOutput("pixels_accepted", accepted, NI);
        checkOutput("pixel_ready_after_load", pixel_ready, 0);
        checkOutput("busy_during_run", busy, 1);
        if (abortTs >= 0) begin
            while (cyc < lastCyc + abortTs * (NI + 1) + 6) @(negedge clk);
            #1 rst = 1'b1;
            #1;
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_counts", spike_counts, 0);
            checkOutput("abort_winner", winner, 0);
            checkOutput("abort_out_spikes", out_spikes, 0);
            checkOutput("abort_pixel_ready", pixel_ready, 0);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < NI; i++)
                for (int j = 0; j < NO; j++) tbW[i][j] = 0;
            checkOutput("abort_spk_drained", spkQ.size(), 0);
            repeat (NT * (NI + 1) + 4) @(negedge clk);
            checkOutput("abort_no_done_busy", busy, 0);
        end else begin
            for (int j = 0; j < NO; j++) r.counts[j*CW +: CW] = CW'(mCnt[j]);
            r.win = 2'(mWin);
            r.doneCyc = lastCyc + NT * (NI + 1) + 1;
            resQ.push_back(r);
            guard = 0;
            while (!done && guard < 1000) begin
                if (busyPoke && guard == 20) begin
                    start = 1'b1; weight_wen = 1'b1; pixel_valid = 1'b1;
                    weight_addr_row = 4'($urandom); weight_addr_col = 2'($urandom);
                    weight_data = 8'($urandom);
                end else begin
                    start = 1'b0; weight_wen = 1'b0; pixel_valid = 1'b0;
                end
                @(negedge clk);
                guard++;
            end
            start = 1'b0; weight_wen = 1'b0; pixel_valid = 1'b0;
            if (!done) begin
                nChecks++;
                $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", guard);
            end
            repeat (2) @(negedge clk);
            checkOutput("counts_hold", spike_counts, r.counts);
            checkOutput("winner_hold", winner, r.win);
            checkOutput("result_queue_drained", resQ.size(), 0);
            checkOutput("spike_queue_drained", spkQ.size(), 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_threshold = '0; cfg_leak_shift = '0;
        weight_wen = 1'b0; weight_addr_row = '0; weight_addr_col = '0; weight_data = '0;
        pixel_data = '0; pixel_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tbPix[i] = 0;
            for (int j = 0; j < NO; j++) tbW[i][j] = 0;
        end

        // Reset held while inputs toggle.
        repeat (6) begin
            @(negedge clk);
            start = 1'($urandom); weight_wen = 1'($urandom); pixel_valid = 1'($urandom);
            weight_data = 8'($urandom); pixel_data = 8'($urandom);
        end
        checkOutput("reset_pixel_ready", pixel_ready, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_out_valid", out_spikes_valid, 0);
        checkOutput("reset_out_spikes", out_spikes, 0);
        checkOutput("reset_counts", spike_counts, 0);
        checkOutput("reset_winner", winner, 0);
        @(negedge clk);
        start = 1'b0; weight_wen = 1'b0; pixel_valid = 1'b0; rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_pixel_ready", pixel_ready, 0);

        // pixel_valid in IDLE is never accepted.
        for (int k = 0; k < 5; k++) begin
            pixel_valid = 1'b1;
            pixel_data = 8'($urandom);
            @(negedge clk);
            checkOutput("idle_pixel_refused", pixel_ready, 0);
        end
        pixel_valid = 1'b0;
        checkOutput("idle_still_idle", busy, 0);

        // Single strong synapse always fires.
        writeWeight(0, 3, 127);
        tbPix[0] = 255;
        pulseCnt = 0;
        applyStimulus(100, 0, -1, 1'b0, 1'b0);
        checkOutput("sc2_counts", spike_counts, {16'd4, 16'd0, 16'd0, 16'd0});
        checkOutput("sc2_winner", winner, 3);
        checkOutput("sc2_pulses", pulseCnt, 4);

        // Sub-threshold weight with and without leak.
        writeWeight(0, 3, 0);
        writeWeight(0, 0, 60);
        applyStimulus(100, 0, -1, 1'b0, 1'b0);
        checkOutput("leak0_count0", spike_counts[15:0], 2);
        applyStimulus(100, 1, -1, 1'b0, 1'b0);
        checkOutput("leak1_count0", spike_counts[15:0], 1);

        // Tie resolves to the lowest index; silent input gives winner 0.
        writeWeight(0, 0, 0);
        writeWeight(0, 1, 127);
        writeWeight(0, 2, 127);
        applyStimulus(1, 0, -1, 1'b0, 1'b0);
        checkOutput("tie_counts", spike_counts, {16'd0, 16'd4, 16'd4, 16'd0});
        checkOutput("tie_winner", winner, 1);
        tbPix[0] = 0;
        applyStimulus(1, 0, -1, 1'b0, 1'b0);
        checkOutput("silent_counts", spike_counts, 0);
        checkOutput("silent_winner", winner, 0);

        // Strongly negative crossbar drives membranes into negative saturation.
        for (int i = 0; i < NI; i++) begin
            tbPix[i] = 255;
            for (int j = 0; j < NO; j++) tbW[i][j] = -128;
        end
        setAllWeights();
        applyStimulus(100, 0, -1, 1'b0, 1'b0);
        checkOutput("negsat_counts", spike_counts, 0);

        // Randomised frames, weights and configuration.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NI; i++) begin
                int sel;
                sel = int'($urandom_range(0, 3));
                tbPix[i] = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(0, 255));
                for (int j = 0; j < NO; j++) tbW[i][j] = int'($urandom_range(0, 255)) - 128;
            end
            setAllWeights();
            applyStimulus(int'($urandom_range(0, 800)) - 100, int'($urandom_range(0, 15)), -1,
                          (k == 5), (k == 3));
        end

        // Reset during the third timestep, then a fresh run of the single-synapse case.
        for (int i = 0; i < NI; i++) begin
            tbPix[i] = 0;
            for (int j = 0; j < NO; j++) tbW[i][j] = 0;
        end
        tbW[0][3] = 127;
        tbPix[0] = 255;
        setAllWeights();
        applyStimulus(100, 0, 2, 1'b0, 1'b0);
        writeWeight(0, 3, 127);
        applyStimulus(100, 0, -1, 1'b0, 1'b0);
        checkOutput("rerun_counts", spike_counts, {16'd4, 16'd0, 16'd0, 16'd0});
        checkOutput("rerun_winner", winner, 3);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
